// File: rtl/timer_arbiter_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
package timer_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} tarb_state_t;

    localparam int MAX_REQ = 32;

    // Index of the set bit in a one-hot vector; zero when the vector is empty.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDXW  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  rr_ptr,
    output logic [IDXW-1:0]  win_idx,
    output logic             win_valid
);

    always_comb begin
        int idx;
        win_idx   = '0;
        win_valid = 1'b0;
        // Scan from the farthest offset down so the nearest candidate is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (req[idx]) begin
                win_idx   = IDXW'(idx);
                win_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// One shared interval timer handed out round-robin; the winner's duration is counted
// down in prescaled ticks and a one-cycle done pulse marks expiry.
module timer_arbiter
    import timer_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 24,
    parameter int PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] dur,
    input  logic [N_REQ-1:0]       cancel,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
);

    localparam int IDXW = $clog2(N_REQ);
    localparam int PW   = $clog2(PRESCALE) + 1;
    localparam logic [PW-1:0] TICK_AT = PW'(PRESCALE - 1);

    tarb_state_t      state, state_nx;
    logic [N_REQ-1:0] gnt_nx, done_nx;
    logic [IDXW-1:0]  rr_ptr, rr_ptr_nx;
    logic [WIDTH-1:0] remaining, remaining_nx;
    logic [PW-1:0]    pcnt, pcnt_nx;

    logic [IDXW-1:0]  pick_idx, win_idx, win_succ;
    logic             pick_valid, tick;
    logic [WIDTH-1:0] pick_dur;

    rr_pick #(.N_REQ(N_REQ), .IDXW(IDXW)) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .win_idx   (pick_idx),
        .win_valid (pick_valid)
    );

    // The current winner is recovered from the one-hot grant rather than stored twice.
    assign win_idx  = IDXW'(onehot_to_idx(MAX_REQ'(gnt)));
    assign win_succ = (win_idx == IDXW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign pick_dur = dur[pick_idx*WIDTH +: WIDTH];
    assign tick     = (state == RUN) && (pcnt == TICK_AT);
    assign busy     = |gnt;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx     = state;
        gnt_nx       = gnt;
        done_nx      = '0;
        rr_ptr_nx    = rr_ptr;
        remaining_nx = remaining;
        pcnt_nx      = pcnt;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_nx     = RUN;
                    gnt_nx       = N_REQ'(1) << pick_idx;
                    remaining_nx = (pick_dur == '0) ? WIDTH'(1) : pick_dur;
                    pcnt_nx      = '0;
                end
            end
            RUN: begin
                // Cancel is checked first so it beats an expiry landing on the same edge.
                if (cancel[win_idx]) begin
                    state_nx  = IDLE;
                    gnt_nx    = '0;
                    rr_ptr_nx = win_succ;
                end else if (tick) begin
                    pcnt_nx = '0;
                    if (remaining == WIDTH'(1)) begin
                        state_nx = DONE;
                        done_nx  = gnt;
                    end else begin
                        remaining_nx = remaining - 1'b1;
                    end
                end else begin
                    pcnt_nx = pcnt + 1'b1;
                end
            end
            DONE: begin
                state_nx  = IDLE;
                gnt_nx    = '0;
                rr_ptr_nx = win_succ;
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            done      <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            pcnt      <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            done      <= done_nx;
            rr_ptr    <= rr_ptr_nx;
            remaining <= remaining_nx;
            pcnt      <= pcnt_nx;
        end
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench: stimulus pushes expected grant/done/release events, a monitor
// pops and compares each event the two DUTs (PRESCALE 1 and 3) present.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 24;

    typedef enum int {EV_GNT, EV_DONE, EV_FALL} ev_kind_t;
    typedef struct {
        int         dut;
        ev_kind_t   kind;
        logic [3:0] val;
        int         cyc;
    } ev_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req0, req1, cancel0, cancel1;
    logic [N*W-1:0] dur0, dur1;
    logic [N-1:0]   gnt0, gnt1, done0, done1;
    logic           busy0, busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   quiet = 1'b0;
    bit   fin_req = 1'b0;
    bit   mon_done = 1'b0;
    ev_t  exp_q[$];
    logic [3:0] prev_gnt [2] = '{4'b0, 4'b0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    timer_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(1)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .dur(dur0), .cancel(cancel0),
        .gnt(gnt0), .done(done0), .busy(busy0)
    );

    timer_arbiter #(.N_REQ(N), .WIDTH(W), .PRESCALE(3)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .dur(dur1), .cancel(cancel1),
        .gnt(gnt1), .done(done1), .busy(busy1)
    );

    task automatic push(input int d, input ev_kind_t k, input logic [3:0] v, input int c);
        ev_t e;
        e.dut = d; e.kind = k; e.val = v; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Grant visible at cycle g, done after d*p cycles, release one cycle later.
    task automatic expect_run(input int d, input logic [3:0] v, input int g, input int dd, input int p);
        push(d, EV_GNT, v, g);
        push(d, EV_DONE, v, g + dd * p);
        push(d, EV_FALL, 4'b0, g + dd * p + 1);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic observe(input int d, input ev_kind_t k, input logic [3:0] v, input logic b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected dut%0d cyc %0d: got %s val=%b, expected no event", d, cyc, k.name(), v);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != d || e.kind != k || e.val != v || e.cyc != cyc || b != (k != EV_FALL)) begin
                errors++;
                $display("FAIL event dut%0d cyc %0d: got %s val=%b busy=%b, expected dut%0d %s val=%b cyc %0d busy=%b",
                         d, cyc, k.name(), v, b, e.dut, e.kind.name(), e.val, e.cyc, (e.kind != EV_FALL));
            end
        end
    endtask

    always @(negedge clk) begin
        logic [3:0] g, dn;
        logic       b;
        for (int d = 0; d < 2; d++) begin
            g  = (d == 0) ? gnt0 : gnt1;
            dn = (d == 0) ? done0 : done1;
            b  = (d == 0) ? busy0 : busy1;
            if (quiet) begin
                checks++;
                if ({g, dn, b} !== 9'b0) begin
                    errors++;
                    $display("FAIL quiet dut%0d cyc %0d: got gnt=%b done=%b busy=%b, expected all 0", d, cyc, g, dn, b);
                end
            end
            if (dn != 4'b0) observe(d, EV_DONE, dn, b);
            if (g != prev_gnt[d]) observe(d, (g != 4'b0) ? EV_GNT : EV_FALL, g, b);
            prev_gnt[d] = g;
        end
        if (fin_req && !mon_done) begin
            while (exp_q.size() > 0) begin
                ev_t e;
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing dut%0d: got nothing, expected %s val=%b at cyc %0d", e.dut, e.kind.name(), e.val, e.cyc);
            end
            mon_done = 1'b1;
        end
    end

    initial begin
        int c;
        reset = 1'b1; req0 = '1; req1 = '1;
        cancel0 = '0; cancel1 = '0; dur0 = '0; dur1 = '0;

        // Reset held 3 edges with all requests high, then one cycle after release.
        wait_to(1); quiet = 1'b1;
        wait_to(3); reset = 1'b0; req0 = '0; req1 = '0;
        wait_to(4); quiet = 1'b0;

        // All four requesting, dur=2: order 0,1,2,3,0 with one idle cycle between.
        c = cyc;
        req0 = 4'b1111;
        for (int i = 0; i < N; i++) dur0[i*W +: W] = W'(2);
        expect_run(0, 4'b0001, c + 1, 2, 1);
        expect_run(0, 4'b0010, c + 5, 2, 1);
        expect_run(0, 4'b0100, c + 9, 2, 1);
        expect_run(0, 4'b1000, c + 13, 2, 1);
        expect_run(0, 4'b0001, c + 17, 2, 1);
        wait_to(c + 17); req0 = '0;
        wait_to(c + 22);

        // Single requester 0, dur=5 (pointer wraps from 1); later dur change ignored.
        c = cyc;
        req0 = 4'b0001; dur0[0 +: W] = W'(5);
        expect_run(0, 4'b0001, c + 1, 5, 1);
        wait_to(c + 1); req0 = '0; dur0[0 +: W] = W'(1);
        wait_to(c + 9);

        // Cancel of the winner at cycle 4; foreign cancel ignored; requester 1 next.
        reset = 1'b1; wait_to(cyc + 1); reset = 1'b0;
        c = cyc;
        req0 = 4'b0011; dur0[0 +: W] = W'(10); dur0[W +: W] = W'(3);
        push(0, EV_GNT, 4'b0001, c + 1);
        push(0, EV_FALL, 4'b0000, c + 5);
        expect_run(0, 4'b0010, c + 6, 3, 1);
        wait_to(c + 1); req0 = 4'b0010; cancel0 = 4'b0010;
        wait_to(c + 3); cancel0 = '0;
        wait_to(c + 4); cancel0 = 4'b0001;
        wait_to(c + 5); cancel0 = '0;
        wait_to(c + 6); req0 = '0;
        wait_to(c + 12);

        // PRESCALE=3: dur=2 gives done 6 cycles after grant, dur=0 gives 3.
        c = cyc;
        req1 = 4'b0001; dur1[0 +: W] = W'(2);
        expect_run(1, 4'b0001, c + 1, 2, 3);
        wait_to(c + 1); req1 = '0;
        wait_to(c + 10);
        c = cyc;
        req1 = 4'b0001; dur1[0 +: W] = W'(0);
        expect_run(1, 4'b0001, c + 1, 1, 3);
        wait_to(c + 1); req1 = '0;
        wait_to(c + 7);

        // Reset in cycle 3 of a dur=8 run: no done, then requester 3 alone is granted.
        c = cyc;
        req0 = 4'b0100; dur0[2*W +: W] = W'(8);
        push(0, EV_GNT, 4'b0100, c + 1);
        push(0, EV_FALL, 4'b0000, c + 4);
        wait_to(c + 1); req0 = '0;
        wait_to(c + 3); reset = 1'b1;
        wait_to(c + 4); reset = 1'b0; req0 = 4'b1000; dur0[3*W +: W] = W'(1);
        expect_run(0, 4'b1000, c + 5, 1, 1);
        wait_to(c + 5); req0 = '0;
        wait_to(c + 9);

        fin_req = 1'b1;
        wait_to(cyc + 2);
        if (!mon_done) $fatal(1, "FAIL monitor did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
